serializer_mlane: RTL and testbench

Multi-lane SDR/DDR parallel-to-serial transmitter with a forwarded half-rate clock and a valid/ready input handshake. It is the successor to the single-lane serializer and feeds the ISERDES SDR/DDR minitests with several data lanes that share one O_CLK. A 1-deep holding register decouples the producer. When no word is pending, an IDLE pattern is sent and underrun is flagged.

---
 rtl/serializer_mlane.sv | 225 ++++++++++++++++++++++
 tb/tb_serializer_mlane.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_mlane.sv
//----------------------------------------------------------------------------
// serializer_mlane
//
// Multi-lane parallel-to-serial transmitter with a forwarded half-rate clock.
// Every lane shares one O_CLK, one beat counter and one 1-deep holding
// register, so all lanes start and finish their words on the same beat.
// When no word is waiting at a load boundary the IDLE pattern is sent on
// every lane and UNDERRUN is pulsed.
//
// Parameters
//   WIDTH  bits per word per lane (2..32, even in DDR mode)
//   LANES  number of serial data lanes (1..16)
//   MODE   "SDR" (1 bit per O_CLK period) or "DDR" (2 bits per O_CLK period)
//   IDLE   WIDTH-bit pattern loaded into every lane on underrun
//
// Ports
//   CLK       bit clock; O_CLK runs at CLK/2
//   RST       synchronous, active-high reset
//   I         input word, lane k = I[k*WIDTH +: WIDTH]
//   I_VALID   word on I is valid
//   I_READY   block accepts I this cycle
//   BITSLIP   one-cycle pulse, rotates lane alignment by one beat
//   LOAD      strobe: shift registers load this cycle
//   UNDERRUN  strobe: IDLE was loaded instead of data
//   CE        beat enable (= !O_CLK)
//   O_CLK     forwarded clock
//   O_DAT     serial data, bit k = lane k, MSB first
//
// Build option
//   SERIALIZER_BITSLIP_EN  when defined, BITSLIP advances a shared slip
//                          count (mod beats-per-word) and every loaded word
//                          is rotated left by slip*bits-per-beat. When not
//                          defined, BITSLIP is ignored and no rotation logic
//                          is built.
//----------------------------------------------------------------------------
module serializer_mlane #(
    parameter int               WIDTH = 8,
    parameter int               LANES = 2,
    parameter                   MODE  = "SDR",
    parameter logic [WIDTH-1:0] IDLE  = '0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [WIDTH*LANES-1:0] I,
    input  logic                   I_VALID,
    output logic                   I_READY,
    input  logic                   BITSLIP,
    output logic                   LOAD,
    output logic                   UNDERRUN,
    output logic                   CE,
    output logic                   O_CLK,
    output logic [LANES-1:0]       O_DAT
);

    localparam bit              IS_DDR = (MODE == "DDR");
    localparam int              B      = IS_DDR ? 2 : 1;
    localparam int              N      = WIDTH / B;
    localparam int              CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST   = CW'(N - 1);

    // Reject configurations the datapath cannot represent.
    generate
        if (MODE != "SDR" && MODE != "DDR") begin : g_bad_mode
            $error("serializer_mlane: MODE must be SDR or DDR");
        end
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("serializer_mlane: WIDTH must be in 2..32");
        end
        if (IS_DDR && (WIDTH % 2) != 0) begin : g_odd_ddr
            $error("serializer_mlane: WIDTH must be even in DDR mode");
        end
        if (LANES < 1 || LANES > 16) begin : g_bad_lanes
            $error("serializer_mlane: LANES must be in 1..16");
        end
    endgenerate

    logic                   o_clk;
    logic [CW-1:0]          count;
    logic                   hold_full;
    logic [WIDTH*LANES-1:0] hold_reg;
    logic                   ce;
    logic                   load_now;
    logic                   take;

    // A beat happens on every low phase of the forwarded clock; the word
    // boundary is the beat where the down-counter sits at zero.
    assign ce       = ~o_clk;
    assign load_now = ce && (count == '0);

    // The holding register can accept a new word when it is empty, or on the
    // very cycle its current word is being moved into the shift registers.
    // Nothing is accepted while reset is applied, since it would be dropped.
    assign I_READY  = !RST && (!hold_full || load_now);
    assign take     = I_VALID && I_READY;

    assign LOAD     = !RST && load_now;
    assign UNDERRUN = !RST && load_now && !hold_full;
    assign CE       = ce;
    assign O_CLK    = o_clk;

    // Forwarded clock and beat counter. The counter starts at zero so the
    // first beat after reset is already a load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            o_clk <= 1'b1;
            count <= '0;
        end else begin
            o_clk <= ~o_clk;
            if (ce) begin
                count <= (count == '0) ? LAST : count - 1'b1;
            end
        end
    end

    // Holding register occupancy. An accept wins over a simultaneous load so
    // the newly accepted word stays pending behind the one being consumed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_full <= 1'b0;
        end else if (take) begin
            hold_full <= 1'b1;
        end else if (load_now) begin
            hold_full <= 1'b0;
        end
    end

    // Held data needs no reset: it is only used while hold_full is set.
    always_ff @(posedge CLK) begin
        if (take) begin
            hold_reg <= I;
        end
    end

`ifdef SERIALIZER_BITSLIP_EN
    logic [CW-1:0] slip;

    // Shared lane alignment. It is sampled at each load, so a pulse that
    // lands on a load cycle takes effect from the following word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            slip <= '0;
        end else if (BITSLIP) begin
            slip <= (slip == LAST) ? '0 : slip + 1'b1;
        end
    end

    // Rotate left by whole beats; the shift of the doubled word brings the
    // wrapped-around high bits back in at the bottom.
    function automatic logic [WIDTH-1:0] rotl_beats(input logic [WIDTH-1:0] w,
                                                    input logic [CW-1:0]    s);
        logic [2*WIDTH-1:0] d;
        d = {w, w} << (s * B);
        return d[2*WIDTH-1:WIDTH];
    endfunction
`else
    logic unused_bitslip;
    assign unused_bitslip = BITSLIP;
`endif

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [WIDTH-1:0] word_sel;
            logic [WIDTH-1:0] word_in;
            logic [WIDTH-1:0] sreg;
            logic             dat_q;

            assign word_sel = hold_full ? hold_reg[k*WIDTH +: WIDTH] : IDLE;
`ifdef SERIALIZER_BITSLIP_EN
            assign word_in  = rotl_beats(word_sel, slip);
`else
            assign word_in  = word_sel;
`endif

            // Shift register: load at the word boundary, otherwise move the
            // next beat's bits to the top on every beat.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    sreg <= '0;
                end else if (load_now) begin
                    sreg <= word_in;
                end else if (ce) begin
                    sreg <= sreg << B;
                end
            end

            if (IS_DDR) begin : g_ddr
                logic lo;

                // Both bits of a beat are captured together on the CE cycle;
                // the second one is replayed during the following high phase
                // of O_CLK so the pair shares one O_CLK period.
                always_ff @(posedge CLK) begin
                    if (RST) begin
                        dat_q <= 1'b0;
                        lo    <= 1'b0;
                    end else if (ce) begin
                        dat_q <= sreg[WIDTH-1];
                        lo    <= sreg[WIDTH-2];
                    end else begin
                        dat_q <= lo;
                    end
                end
            end else begin : g_sdr
                always_ff @(posedge CLK) begin
                    if (RST) begin
                        dat_q <= 1'b0;
                    end else if (ce) begin
                        dat_q <= sreg[WIDTH-1];
                    end
                end
            end

            assign O_DAT[k] = dat_q;
        end
    endgenerate

    // A pending word must never be replaced before it has been loaded.
    a_no_overwrite : assert property (@(posedge CLK) disable iff (RST)
        take |-> (!hold_full || load_now));

    // The beat counter stays inside one word.
    a_count_range : assert property (@(posedge CLK) disable iff (RST)
        count <= LAST);

endmodule

// File: tb/tb_serializer_mlane.sv
//----------------------------------------------------------------------------
// tb_serializer_mlane
//
// Drives an SDR instance (WIDTH=8, LANES=2, IDLE=8'hF0) and a DDR instance
// (WIDTH=4, LANES=1). A cycle-level model of the SDR instance keeps a queue
// of accepted words, predicts every load and checks each serial word it
// produces; directed sequences cover the DDR pattern, underrun, reset in the
// middle of a word and bit slipping.
//----------------------------------------------------------------------------
module tb_serializer_mlane;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;

    // SDR instance
    logic [15:0] sdr_i       = '0;
    logic        sdr_valid   = 1'b0;
    logic        sdr_bitslip = 1'b0;
    logic        sdr_ready;
    logic        sdr_load;
    logic        sdr_under;
    logic        sdr_ce;
    logic        sdr_oclk;
    logic [1:0]  sdr_odat;

    serializer_mlane #(
        .WIDTH (8),
        .LANES (2),
        .MODE  ("SDR"),
        .IDLE  (8'hF0)
    ) u_sdr (
        .CLK      (CLK),
        .RST      (RST),
        .I        (sdr_i),
        .I_VALID  (sdr_valid),
        .I_READY  (sdr_ready),
        .BITSLIP  (sdr_bitslip),
        .LOAD     (sdr_load),
        .UNDERRUN (sdr_under),
        .CE       (sdr_ce),
        .O_CLK    (sdr_oclk),
        .O_DAT    (sdr_odat)
    );

    // DDR instance
    logic [3:0]  ddr_i       = '0;
    logic        ddr_valid   = 1'b0;
    logic        ddr_bitslip = 1'b0;
    logic        ddr_ready;
    logic        ddr_load;
    logic        ddr_under;
    logic        ddr_ce;
    logic        ddr_oclk;
    logic [0:0]  ddr_odat;

    serializer_mlane #(
        .WIDTH (4),
        .LANES (1),
        .MODE  ("DDR"),
        .IDLE  (4'h0)
    ) u_ddr (
        .CLK      (CLK),
        .RST      (RST),
        .I        (ddr_i),
        .I_VALID  (ddr_valid),
        .I_READY  (ddr_ready),
        .BITSLIP  (ddr_bitslip),
        .LOAD     (ddr_load),
        .UNDERRUN (ddr_under),
        .CE       (ddr_ce),
        .O_CLK    (ddr_oclk),
        .O_DAT    (ddr_odat)
    );

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < s; i++) begin
            r = {r[6:0], r[7]};
        end
        return r;
    endfunction

    // ---------------- scoreboard / model of the SDR instance ----------------
    typedef struct {
        int          t;
        logic [15:0] word;
        bit          is_data;
    } load_rec_t;

    load_rec_t   loadq[$];
    logic [15:0] sbq[$];
    int          cyc        = 0;
    int          data_words = 0;
    bit          m_active   = 1'b0;
    bit          m_oclk     = 1'b1;
    int          m_cnt      = 0;
    int          m_slip     = 0;
    logic [7:0]  asm_a [2];
    logic [7:0]  asm_b [2];

    always @(negedge CLK) begin
        bit          m_ce;
        bit          m_load;
        bit          m_ready;
        bit          m_full;
        int          off;
        logic [15:0] src;
        load_rec_t   rec;
        cyc++;
        if (RST) begin
            m_active = 1'b1;
            m_oclk   = 1'b1;
            m_cnt    = 0;
            m_slip   = 0;
            sbq.delete();
            loadq.delete();
        end else if (m_active) begin
            m_full  = (sbq.size() != 0);
            m_ce    = !m_oclk;
            m_load  = m_ce && (m_cnt == 0);
            m_ready = !m_full || m_load;
            check_output("ctrl", {sdr_oclk, sdr_ce, sdr_ready, sdr_load, sdr_under},
                         {m_oclk, m_ce, m_ready, m_load, m_load && !m_full});

            // Each bit of a word appears from load+3 and is held for 2 CLK.
            if (loadq.size() != 0) begin
                off = cyc - loadq[0].t;
                if (off >= 3 && off <= 18) begin
                    for (int ln = 0; ln < 2; ln++) begin
                        if (((off - 3) % 2) == 0) asm_a[ln] = {asm_a[ln][6:0], sdr_odat[ln]};
                        else                      asm_b[ln] = {asm_b[ln][6:0], sdr_odat[ln]};
                    end
                    if (off == 18) begin
                        check_output("stream", {asm_a[1], asm_a[0]}, loadq[0].word);
                        check_output("stream_hold", {asm_b[1], asm_b[0]}, loadq[0].word);
                        if (loadq[0].is_data) data_words++;
                        void'(loadq.pop_front());
                    end
                end
            end

            if (m_load) begin
                if (m_full) begin
                    src         = sbq.pop_front();
                    rec.is_data = 1'b1;
                end else begin
                    src         = 16'hF0F0;
                    rec.is_data = 1'b0;
                end
                rec.t    = cyc;
                rec.word = {rotl8(src[15:8], m_slip), rotl8(src[7:0], m_slip)};
                loadq.push_back(rec);
            end
            if (sdr_valid && m_ready) sbq.push_back(sdr_i);
`ifdef SERIALIZER_BITSLIP_EN
            if (sdr_bitslip) m_slip = (m_slip + 1) % 8;
`endif
            if (m_ce) m_cnt = (m_cnt == 0) ? 7 : m_cnt - 1;
            m_oclk = !m_oclk;
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(posedge CLK); #1;
        RST         = 1'b1;
        sdr_valid   = 1'b0;
        ddr_valid   = 1'b0;
        sdr_bitslip = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    // Waits for the next SDR load and records the 8 bits of each lane.
    task automatic capture_stream(output logic [7:0] s0, output logic [7:0] s1,
                                  output logic und, output bit seen);
        int n;
        n    = 0;
        s0   = '0;
        s1   = '0;
        und  = 1'b0;
        @(negedge CLK);
        while (!sdr_load && n < 40) begin
            @(negedge CLK);
            n++;
        end
        seen = sdr_load;
        if (seen) begin
            und = sdr_under;
            for (int k = 0; k < 8; k++) begin
                repeat ((k == 0) ? 3 : 2) @(negedge CLK);
                s0 = {s0[6:0], sdr_odat[0]};
                s1 = {s1[6:0], sdr_odat[1]};
            end
        end
    endtask

    typedef struct {
        bit          valid;
        logic [15:0] word;
        logic [7:0]  exp0;
        logic [7:0]  exp1;
        bit          exp_under;
    } vec_t;

    task automatic apply_stimulus(input vec_t v, input int idx);
        logic [7:0] s0, s1;
        logic       und;
        bit         seen;
        do_reset();
        sdr_i     = v.word;
        sdr_valid = v.valid;
        capture_stream(s0, s1, und, seen);
        check_output($sformatf("vec%0d_load_seen", idx), seen, 1);
        check_output($sformatf("vec%0d_underrun", idx), und, v.exp_under);
        check_output($sformatf("vec%0d_lane0", idx), s0, v.exp0);
        check_output($sformatf("vec%0d_lane1", idx), s1, v.exp1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t       vecs[4];
        logic [7:0] s0, s1;
        logic       und;
        bit         seen;
        bit         acc;
        int         n;
        int         start;
        logic [7:0] ddr_exp;
        logic [7:0] slip_exp;

        vecs[0] = '{1'b1, 16'hA53C, 8'b00111100, 8'b10100101, 1'b0};
        vecs[1] = '{1'b1, 16'h00FF, 8'b11111111, 8'b00000000, 1'b0};
        vecs[2] = '{1'b1, 16'h8001, 8'b00000001, 8'b10000000, 1'b0};
        vecs[3] = '{1'b0, 16'h1234, 8'b11110000, 8'b11110000, 1'b1};

        // Reset state of both instances.
        do_reset();
        @(negedge CLK);
        check_output("sdr_reset_state", {sdr_oclk, sdr_ce, sdr_ready, sdr_load, sdr_under, sdr_odat},
                     7'b1010000);
        check_output("ddr_reset_state", {ddr_oclk, ddr_ce, ddr_ready, ddr_load, ddr_under, ddr_odat},
                     6'b101000);

        // DDR: 4'hB then 4'h6 back to back.
        do_reset();
        ddr_i     = 4'hB;
        ddr_valid = 1'b1;
        @(negedge CLK);
        check_output("ddr_ready_after_reset", ddr_ready, 1);
        @(posedge CLK); #1;
        ddr_i = 4'h6;
        @(negedge CLK);
        check_output("ddr_first_load", {ddr_load, ddr_ready, ddr_under}, 3'b110);
        @(posedge CLK); #1;
        ddr_valid = 1'b0;
        ddr_exp   = 8'b10110110;
        for (int c = 2; c <= 11; c++) begin
            @(negedge CLK);
            if (c >= 4) check_output($sformatf("ddr_bit%0d", c - 4), ddr_odat, ddr_exp[11 - c]);
            if (c <= 8) check_output($sformatf("ddr_load_c%0d", c), {ddr_load, ddr_under},
                                     (c == 5) ? 2'b10 : 2'b00);
        end

        // Table of SDR words (including the idle/underrun case).
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i], i);
        end

        // Reset at beat 3 of a word while another word is held.
        do_reset();
        sdr_i     = 16'hC3C3;
        sdr_valid = 1'b1;
        repeat (7) @(posedge CLK);
        #1;
        RST       = 1'b1;
        sdr_valid = 1'b0;
        @(posedge CLK); #1;
        RST       = 1'b0;
        sdr_i     = 16'h1E69;
        sdr_valid = 1'b1;
        @(negedge CLK);
        check_output("rst_mid_odat_oclk", {sdr_odat, sdr_oclk}, 3'b001);
        capture_stream(s0, s1, und, seen);
        sdr_valid = 1'b0;
        check_output("rst_mid_load_seen", seen, 1);
        check_output("rst_mid_lane0", s0, 8'h69);
        check_output("rst_mid_lane1", s1, 8'h1E);

        // Two BITSLIP pulses, one on the first load cycle.
        do_reset();
        sdr_i     = 16'h0080;
        sdr_valid = 1'b1;
        @(posedge CLK); #1; sdr_bitslip = 1'b1;
        @(posedge CLK); #1; sdr_bitslip = 1'b0;
        @(posedge CLK); #1; sdr_bitslip = 1'b1;
        @(posedge CLK); #1; sdr_bitslip = 1'b0;
        capture_stream(s0, s1, und, seen);
`ifdef SERIALIZER_BITSLIP_EN
        slip_exp = 8'h02;
`else
        slip_exp = 8'h80;
`endif
        check_output("bitslip_load_seen", seen, 1);
        check_output("bitslip_lane0", s0, slip_exp);
        check_output("bitslip_lane1", s1, 8'h00);
        sdr_valid = 1'b0;

        // 64 random words with random producer gaps.
        do_reset();
        start = data_words;
        for (int w = 0; w < 64; w++) begin
            if ($urandom_range(0, 3) == 0) begin
                sdr_valid = 1'b0;
                repeat ($urandom_range(1, 20)) begin
                    @(posedge CLK); #1;
                end
            end
            sdr_i     = 16'($urandom);
            sdr_valid = 1'b1;
            n   = 0;
            acc = 1'b0;
            while (!acc && n < 40) begin
                @(negedge CLK);
                acc = sdr_ready;
                @(posedge CLK); #1;
                n++;
            end
            check_output($sformatf("rand_accept%0d", w), acc, 1);
        end
        sdr_valid = 1'b0;
        repeat (40) @(negedge CLK);
        check_output("rand_drain", data_words - start, 64);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
